// File: rtl/log_mem_rd_arbiter_pkg.sv
// Shared types and constants for the log memory read arbiter.
package log_mem_arb_pkg;

  localparam int NUM_SRC = 2;

  typedef logic [0:0] arb_src_id_t;

  localparam arb_src_id_t ARB_SRC_LOG_READER = 1'b0;
  localparam arb_src_id_t ARB_SRC_AUX        = 1'b1;

endpackage

// File: rtl/log_mem_rd_arbiter_if.sv
// Bundle of source-side and memory-side read channels around the arbiter.
// slave = arbiter view, master = environment (sources + memory) view.
interface log_mem_rd_arbiter_if #(
  parameter int ADDR_W          = 8,
  parameter int DATA_W          = 512,
  parameter int MAX_OUTSTANDING = 4
);
  import log_mem_arb_pkg::*;

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  // Source side
  logic [NUM_SRC-1:0]             src_arb_rd_req_val;
  logic [NUM_SRC-1:0][ADDR_W-1:0] src_arb_rd_req_addr;
  logic [NUM_SRC-1:0]             arb_src_rd_req_rdy;
  logic [NUM_SRC-1:0]             arb_src_rd_resp_val;
  logic [DATA_W-1:0]              arb_src_rd_resp_data;
  logic [NUM_SRC-1:0]             src_arb_rd_resp_rdy;

  // Memory side
  logic                           arb_mem_rd_req_val;
  logic [ADDR_W-1:0]              arb_mem_rd_req_addr;
  logic                           mem_arb_rd_req_rdy;
  logic                           mem_arb_rd_resp_val;
  logic [DATA_W-1:0]              mem_arb_rd_resp_data;
  logic                           arb_mem_rd_resp_rdy;

  // Status
  logic [CNT_W-1:0]               outstanding_cnt;
  logic                           resp_err;

  modport slave (
    input  src_arb_rd_req_val, src_arb_rd_req_addr, src_arb_rd_resp_rdy,
           mem_arb_rd_req_rdy, mem_arb_rd_resp_val, mem_arb_rd_resp_data,
    output arb_src_rd_req_rdy, arb_src_rd_resp_val, arb_src_rd_resp_data,
           arb_mem_rd_req_val, arb_mem_rd_req_addr, arb_mem_rd_resp_rdy,
           outstanding_cnt, resp_err
  );

  modport master (
    output src_arb_rd_req_val, src_arb_rd_req_addr, src_arb_rd_resp_rdy,
           mem_arb_rd_req_rdy, mem_arb_rd_resp_val, mem_arb_rd_resp_data,
    input  arb_src_rd_req_rdy, arb_src_rd_resp_val, arb_src_rd_resp_data,
           arb_mem_rd_req_val, arb_mem_rd_req_addr, arb_mem_rd_resp_rdy,
           outstanding_cnt, resp_err
  );

endinterface

// File: rtl/log_mem_rd_tag_fifo.sv
// In-order tag FIFO: records which source issued each in-flight read.
// DEPTH must be a power of two so the pointers wrap naturally.
module log_mem_rd_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state for pointers and occupancy; push+pop together leaves count unchanged
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage; contents are only meaningful between push and pop
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/log_mem_rd_arbiter.sv
// Two-source read arbiter in front of one log memory read port.
// Source 0 = log reader, source 1 = auxiliary reader.
// Define LOG_MEM_RD_ARB_FIXED_PRIO_EN for strict priority to source 0;
// otherwise grants alternate round-robin.
module log_mem_rd_arbiter
  import log_mem_arb_pkg::*;
#(
  parameter int ADDR_W          = 8,
  parameter int DATA_W          = 512,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  log_mem_rd_arbiter_if.slave  arb_if
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  arb_src_id_t        grant;
  logic               any_val;
  logic [ADDR_W-1:0]  req_addr;
  logic [NUM_SRC-1:0] req_rdy;
  logic               req_val;
  logic               push;
  logic               pop;
  logic [NUM_SRC-1:0] resp_val;
  logic               mem_resp_rdy;
  logic [DATA_W-1:0]  resp_data;

  arb_src_id_t        head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  logic               resp_err_q, resp_err_d;

`ifndef LOG_MEM_RD_ARB_FIXED_PRIO_EN
  arb_src_id_t        last_grant_q, last_grant_d;
`endif

  // Grant selection among valid sources
  always_comb begin
    any_val = |arb_if.src_arb_rd_req_val;
    grant   = ARB_SRC_LOG_READER;
`ifdef LOG_MEM_RD_ARB_FIXED_PRIO_EN
    if (!arb_if.src_arb_rd_req_val[ARB_SRC_LOG_READER]) grant = ARB_SRC_AUX;
`else
    if (&arb_if.src_arb_rd_req_val)                 grant = ~last_grant_q;
    else if (arb_if.src_arb_rd_req_val[ARB_SRC_AUX]) grant = ARB_SRC_AUX;
`endif
  end

  // Request path: forward granted source; a full tag FIFO blocks issue (no bypass)
  always_comb begin
    req_val  = any_val && !fifo_full;
    req_addr = arb_if.src_arb_rd_req_addr[grant];
    req_rdy  = '0;
    if (any_val) req_rdy[grant] = arb_if.mem_arb_rd_req_rdy && !fifo_full;
    push     = req_val && arb_if.mem_arb_rd_req_rdy;
  end

  // Response path: head tag steers the response; no response accepted when nothing is in flight
  always_comb begin
    resp_val = '0;
    if (!fifo_empty) resp_val[head] = arb_if.mem_arb_rd_resp_val;
    mem_resp_rdy = !fifo_empty && arb_if.src_arb_rd_resp_rdy[head];
    pop          = arb_if.mem_arb_rd_resp_val && mem_resp_rdy;
    resp_err_d   = resp_err_q || (arb_if.mem_arb_rd_resp_val && fifo_empty);
  end

`ifndef LOG_MEM_RD_ARB_FIXED_PRIO_EN
  // Remember last granted source; only a completed handshake moves it
  always_comb begin
    last_grant_d = last_grant_q;
    if (push) last_grant_d = grant;
  end

  // Round-robin pointer register; resets to source 1 so source 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= ARB_SRC_AUX;
    else        last_grant_q <= last_grant_d;
  end
`endif

  // Sticky error for a response arriving with no read in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) resp_err_q <= 1'b0;
    else        resp_err_q <= resp_err_d;
  end

  log_mem_rd_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH ($bits(arb_src_id_t))
  ) u_tag_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (grant),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign resp_data                   = arb_if.mem_arb_rd_resp_data;
  assign arb_if.arb_src_rd_resp_data = resp_data;
  assign arb_if.arb_src_rd_req_rdy   = req_rdy;
  assign arb_if.arb_src_rd_resp_val  = resp_val;
  assign arb_if.arb_mem_rd_req_val   = req_val;
  assign arb_if.arb_mem_rd_req_addr  = req_addr;
  assign arb_if.arb_mem_rd_resp_rdy  = mem_resp_rdy;
  assign arb_if.outstanding_cnt      = fifo_count;
  assign arb_if.resp_err             = resp_err_q;

endmodule

// File: doc/log_mem_rd_arbiter.md
# log_mem_rd_arbiter

Shares one log memory read port (header or data memory) between two requesters: source 0 is the log reader, source 1 is the auxiliary reader (recovery/state-transfer path). Instantiated once in front of the log header memory and once in front of the log data memory. Requests are granted round-robin. An in-order tag FIFO routes each memory response back to the source that issued it. Up to `MAX_OUTSTANDING` reads are allowed in flight.

## Interface
Parameters:
- `ADDR_W`, 8: memory read address width
- `DATA_W`, 512: memory read data width
- `MAX_OUTSTANDING`, 4: tag FIFO depth, power of two, ≥2

Ports:
- `clk` in 1: clock
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `src_arb_rd_req_val` in [1:0]: per-source request valid
- `src_arb_rd_req_addr` in [1:0][ADDR_W-1:0]: per-source read address
- `arb_src_rd_req_rdy` out [1:0]: per-source request ready
- `arb_src_rd_resp_val` out [1:0]: per-source response valid
- `arb_src_rd_resp_data` out DATA_W: response data, broadcast to both sources
- `src_arb_rd_resp_rdy` in [1:0]: per-source response ready
- `arb_mem_rd_req_val` out 1: memory request valid
- `arb_mem_rd_req_addr` out ADDR_W: memory request address
- `mem_arb_rd_req_rdy` in 1: memory request ready
- `mem_arb_rd_resp_val` in 1: memory response valid
- `mem_arb_rd_resp_data` in DATA_W: memory response data
- `arb_mem_rd_resp_rdy` out 1: memory response ready
- `outstanding_cnt` out clog2(MAX_OUTSTANDING)+1: reads currently in flight
- `resp_err` out 1: sticky flag; memory returned a response with no read in flight

## Operation
- Grant selection (combinational): among valid sources, pick the first after `last_grant_reg`. If only one source is valid, it wins.
- `arb_mem_rd_req_val` = any source valid AND tag FIFO not full. Address is muxed from the granted source.
- `arb_src_rd_req_rdy[g]` = `mem_arb_rd_req_rdy` AND not full, for the granted source g only. The other source's ready is 0.
- On a request handshake, two things happen:
  - the grant ID is pushed into the tag FIFO;
  - `last_grant_reg` is set to g. It is not updated without a handshake.
- Full FIFO: no request is issued, even if a pop occurs in the same cycle. There is no bypass.
- Response routing:
  - the head tag h selects the destination;
  - `arb_src_rd_resp_val[h]` = `mem_arb_rd_resp_val` AND FIFO not empty;
  - `arb_mem_rd_resp_rdy` = `src_arb_rd_resp_rdy[h]` AND not empty.
- On a response handshake, the head tag is popped.
- Empty FIFO with `mem_arb_rd_resp_val`=1: `arb_mem_rd_resp_rdy`=0, both resp_val outputs are 0, and `resp_err` is set and held until reset.
- Simultaneous push and pop: count is unchanged; the FIFO pointers both advance.
- Sources may drop a request without a handshake. The grant is re-evaluated every cycle.

## Timing
- Request path and response path: zero-cycle, combinational through the block. There are no combinational paths from any rdy input to any val output.
- Tag push and pop, and the `outstanding_cnt` update, take effect at the clock edge of the handshake.
- A request issued in cycle N has its tag visible for routing from cycle N+1. The memory's minimum read latency is 1 cycle.
- Reset values:
  - `last_grant_reg`=1, so source 0 wins the first tie;
  - FIFO empty, `outstanding_cnt`=0, `resp_err`=0;
  - all val/rdy outputs 0.
- Reset mid-operation clears all in-flight tags. The memory must be reset in the same reset domain; any stale response after reset sets `resp_err`.

## Configuration
- `LOG_MEM_RD_ARB_FIXED_PRIO_EN` defined: strict priority, source 0 always wins when valid. `last_grant_reg` is removed.
- Not defined: round-robin as described above.

## Structure
- Package `log_mem_arb_pkg` holds:
  - `NUM_SRC`=2;
  - `typedef logic [0:0] arb_src_id_t`;
  - source index constants `ARB_SRC_LOG_READER`=0 and `ARB_SRC_AUX`=1.
- Sub-module `log_mem_rd_tag_fifo`: parameterized depth and width, synchronous push/pop, `full`, `empty`, `count` outputs, async active-low reset.

## Test plan
- Single source: source 0 reads addr 0x10, memory returns 0xAA after 3 cycles → `arb_src_rd_resp_val`=2'b01 with data 0xAA; `outstanding_cnt` goes 0→1→0.
- Both sources continuously valid (source 0 addr 0x01, source 1 addr 0x02), memory always ready → memory sees addresses 0x01, 0x02, 0x01, 0x02. With `LOG_MEM_RD_ARB_FIXED_PRIO_EN` defined → 0x01 every cycle.
- Memory stalls responses, 4 requests issued → `outstanding_cnt`=4, both req_rdy 0. First response popped → requests resume the next cycle, not the same cycle.
- Interleaved tags 0,1,1,0 in flight; source 1 holds resp_rdy=0 → second response is stalled at the memory and the third is not delivered early; order is preserved.
- `mem_arb_rd_resp_val` asserted with nothing outstanding → `resp_err`=1 and stays 1; no source resp_val is asserted.
- `rst_n` low with 3 reads in flight → count 0, error flag 0, all outputs 0, and source 0 wins the first grant after reset.
